capture_buffer: RTL and testbench
=================================

CAPTURE_BUFFER -- requirements
Module: capture_buffer

Interface
REQ-001 Parameters SHALL be: SDW, default 32, sample data width; SEW, default 8, event width; AW, default 10, buffer address width (depth 2**AW).
REQ-002 clk  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 sti_tready  output  1  input stream ready.
REQ-005 sti_tvalid  input  1  input sample valid.
REQ-006 sti_tevent  input  SEW  trigger events accompanying the sample.
REQ-007 sti_tdata  input  SDW  sample data.
REQ-008 cfg_arm  input  1  single-cycle arm pulse.
REQ-009 cfg_abort  input  1  single-cycle abort pulse.
REQ-010 cfg_mask  input  SEW  events that fire the capture.
REQ-011 cfg_dly  input  AW  post-trigger sample count.
REQ-012 sto_tready  input  1  readout ready.
REQ-013 sto_tvalid  output  1  readout word valid.
REQ-014 sto_tdata  output  SDW  readout sample.
REQ-015 sto_tlast  output  1  marks final readout word.
REQ-016 sts_state  output  2  current state: 0 IDLE, 1 ARMED, 2 POST, 3 READ.

Function
REQ-017 Transfer on either stream SHALL occur only in a cycle where tvalid and tready are both high.
REQ-018 sti_tready SHALL be high in IDLE, ARMED, POST and low in READ; transfers in IDLE are discarded.
REQ-019 IDLE->ARMED on cfg_arm; write pointer and fill flag cleared to 0 on that edge.
REQ-020 In ARMED and POST every input transfer SHALL write sti_tdata to mem[wptr] and increment wptr modulo 2**AW; fill flag set when wptr wraps from 2**AW-1 to 0.
REQ-021 ARMED->POST on a transfer with |(sti_tevent & cfg_mask); that sample is stored; remaining counter loaded with cfg_dly.
REQ-022 If cfg_dly==0, trigger transfer SHALL go ARMED->READ directly.
REQ-023 In POST each transfer stores the sample and decrements the counter; transfer with counter==1 -> READ.
REQ-024 Events in POST SHALL be ignored (no retrigger).
REQ-025 Readout length = fill ? 2**AW : wptr; start address = fill ? wptr : 0; order oldest-first, address wraps modulo 2**AW.
REQ-026 Memory read is synchronous, 1-cycle latency; first sto_tvalid SHALL rise on the first edge after READ entry.
REQ-027 sto_tvalid held with sto_tdata/sto_tlast stable while sto_tready low; next word presented in the cycle after each transfer with no bubble while sto_tready stays high.
REQ-028 sto_tlast high only with the final word; its transfer SHALL return READ->IDLE and drop sto_tvalid.
REQ-029 cfg_abort in any state SHALL return to IDLE on the next edge, clear sto_tvalid/sto_tlast; abort wins over simultaneous cfg_arm or trigger.
REQ-030 cfg_arm outside IDLE SHALL be ignored.
REQ-031 cfg_mask and cfg_dly SHALL be sampled only on the trigger transfer; later changes do not affect the capture in progress.

Reset
REQ-032 On rst: state IDLE, sts_state 0, sto_tvalid 0, sto_tlast 0, sto_tdata 0, wptr/counter/fill 0; sti_tready SHALL be 1 during and after reset.
REQ-033 Memory contents SHALL NOT be reset; rst mid-capture discards the capture.

Structure
REQ-034 State encodings (IDLE/ARMED/POST/READ) SHALL be shared localparams in include file capture_pkg, also used by the bench.
REQ-035 Storage SHALL be one sub-module capture_ram: simple dual-port, one write port, one synchronous read port, width SDW, depth 2**AW.

Verification (AW=4, depth 16)
REQ-036 Arm, 5 samples 0..4, event on sample 4 with cfg_dly=0 -> readout 0,1,2,3,4, tlast on 4, then IDLE.
REQ-037 Arm, 40 samples value=index, event on sample 30, cfg_dly=3 -> readout 18..33 (16 words), tlast on 33.
REQ-038 Same as REQ-037 with sto_tready toggling 1/0 each cycle -> identical data sequence, no duplicates, tdata stable while stalled.
REQ-039 Abort asserted in POST with cfg_arm same cycle -> IDLE next edge, sto_tvalid never rises, sts_state=0.
REQ-040 Event present in IDLE or on masked-off bit (cfg_mask=0x01, event=0x02) -> no state change from IDLE/ARMED respectively.
REQ-041 rst asserted during READ after 3 words -> next edge sto_tvalid=0, sts_state=0, sti_tready=1.

Source files
------------

// File: rtl/capture_buffer_pkg.sv
// rtl/capture_buffer_pkg.sv - shared state encodings for the capture buffer
package capture_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ARMED = ST_ARMED,
        S_POST  = ST_POST,
        S_READ  = ST_READ
    } state_e;

endpackage

// File: rtl/capture_buffer_if.sv
// rtl/capture_buffer_if.sv - sample input stream and readout stream bundle
interface capture_buffer_if #(
    parameter int SDW = 32,
    parameter int SEW = 8
);
    logic           sti_tready;
    logic           sti_tvalid;
    logic [SEW-1:0] sti_tevent;
    logic [SDW-1:0] sti_tdata;
    logic           sto_tready;
    logic           sto_tvalid;
    logic [SDW-1:0] sto_tdata;
    logic           sto_tlast;

    modport master (
        input  sti_tready,
        output sti_tvalid, sti_tevent, sti_tdata,
        output sto_tready,
        input  sto_tvalid, sto_tdata, sto_tlast
    );

    modport slave (
        output sti_tready,
        input  sti_tvalid, sti_tevent, sti_tdata,
        input  sto_tready,
        output sto_tvalid, sto_tdata, sto_tlast
    );
endinterface

// File: rtl/capture_buffer_ram.sv
// rtl/capture_buffer_ram.sv - simple dual-port sample store, synchronous read
module capture_ram #(
    parameter int SDW = 32,
    parameter int AW  = 10
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [SDW-1:0] wdata,
    input  logic           re,
    input  logic [AW-1:0]  raddr,
    output logic [SDW-1:0] rdata
);
    logic [SDW-1:0] mem [2**AW];

    // No reset: contents survive rst, and the read register holds while re is low.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/capture_buffer.sv
// rtl/capture_buffer.sv - triggered ring-buffer capture with oldest-first readout
module capture_buffer
    import capture_pkg::*;
#(
    parameter int SDW = 32,
    parameter int SEW = 8,
    parameter int AW  = 10
) (
    input  logic            clk,
    input  logic            rst,
    capture_buffer_if.slave s,
    input  logic            cfg_arm,
    input  logic            cfg_abort,
    input  logic [SEW-1:0]  cfg_mask,
    input  logic [AW-1:0]   cfg_dly,
    output logic [1:0]      sts_state
);
    localparam int DEPTH = 1 << AW;

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic          fill_q, fill_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW:0]   rem_q, rem_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          we, re, xfer_in, xfer_out, trig;
    logic [SDW-1:0] rdata;

    assign xfer_in  = s.sti_tvalid && (state_q != S_READ);
    assign xfer_out = valid_q && s.sto_tready;
    assign trig     = |(s.sti_tevent & cfg_mask);

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        last_d  = last_q;
        we      = 1'b0;
        re      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_arm) begin
                    state_d = S_ARMED;
                    wptr_d  = '0;
                    fill_d  = 1'b0;
                end
            end
            S_ARMED, S_POST: begin
                if (xfer_in) begin
                    we     = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    if (wptr_q == '1) fill_d = 1'b1;
                    if (state_q == S_ARMED) begin
                        if (trig) begin
                            cnt_d   = cfg_dly;
                            state_d = (cfg_dly == '0) ? S_READ : S_POST;
                        end
                    end else begin
                        cnt_d = cnt_q - AW'(1);
                        if (cnt_q == AW'(1)) state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (xfer_out && last_q) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (rem_q != '0 && (!valid_q || s.sto_tready)) begin
                    // Prefetch the next word into the RAM read register as the current one leaves.
                    re      = 1'b1;
                    valid_d = 1'b1;
                    last_d  = (rem_q == (AW+1)'(1));
                    raddr_d = raddr_q + AW'(1);
                    rem_d   = rem_q - (AW+1)'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_READ && state_d == S_READ) begin
            raddr_d = fill_d ? wptr_d : '0;
            rem_d   = fill_d ? (AW+1)'(DEPTH) : {1'b0, wptr_d};
        end

        if (cfg_abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            we      = 1'b0;
            re      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            fill_q  <= 1'b0;
            cnt_q   <= '0;
            raddr_q <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    capture_ram #(.SDW(SDW), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr_q),
        .wdata (s.sti_tdata),
        .re    (re),
        .raddr (raddr_q),
        .rdata (rdata)
    );

    assign s.sti_tready = (state_q != S_READ);
    assign s.sto_tvalid = valid_q;
    assign s.sto_tlast  = last_q;
    assign s.sto_tdata  = valid_q ? rdata : '0;
    assign sts_state    = state_q;
endmodule

// File: tb/tb_capture_buffer.sv
// tb/tb_capture_buffer.sv - randomized and directed bench for capture_buffer
module tb_capture_buffer;
    import capture_pkg::*;

    localparam int SDW = 32;
    localparam int SEW = 8;
    localparam int AW  = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_arm = 1'b0;
    logic           cfg_abort = 1'b0;
    logic [SEW-1:0] cfg_mask = '0;
    logic [AW-1:0]  cfg_dly = '0;
    logic [1:0]     sts_state;
    int             rmode = 0;

    capture_buffer_if #(.SDW(SDW), .SEW(SEW)) bus();

    capture_buffer #(.SDW(SDW), .SEW(SEW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (bus),
        .cfg_arm   (cfg_arm),
        .cfg_abort (cfg_abort),
        .cfg_mask  (cfg_mask),
        .cfg_dly   (cfg_dly),
        .sts_state (sts_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: history of accepted samples since arm; readout is its last 2**AW entries.
    int             m_state = 0;
    int             m_cnt = 0;
    bit             m_valid = 0;
    bit             m_pend = 0;
    logic [SDW-1:0] m_hist[$];
    logic [SDW-1:0] m_rd[$];

    function automatic void enter_read();
        int start;
        start = (m_hist.size() > (1 << AW)) ? m_hist.size() - (1 << AW) : 0;
        m_rd.delete();
        for (int k = start; k < m_hist.size(); k++) m_rd.push_back(m_hist[k]);
        m_state = ST_READ;
        m_pend  = 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || cfg_abort) begin
            m_state = ST_IDLE;
            m_valid = 0;
            m_pend  = 0;
            m_rd.delete();
        end else begin
            case (m_state)
                ST_IDLE: if (cfg_arm) begin
                    m_state = ST_ARMED;
                    m_hist.delete();
                end
                ST_ARMED, ST_POST: if (bus.sti_tvalid) begin
                    m_hist.push_back(bus.sti_tdata);
                    if (m_state == ST_ARMED) begin
                        if ((bus.sti_tevent & cfg_mask) != 0) begin
                            m_cnt = cfg_dly;
                            if (m_cnt == 0) enter_read();
                            else m_state = ST_POST;
                        end
                    end else begin
                        m_cnt--;
                        if (m_cnt == 0) enter_read();
                    end
                end
                default: begin
                    if (m_pend) begin
                        m_pend  = 0;
                        m_valid = 1;
                    end else if (m_valid && bus.sto_tready) begin
                        void'(m_rd.pop_front());
                        if (m_rd.size() == 0) begin
                            m_valid = 0;
                            m_state = ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    logic [SDW-1:0] got[$];
    bit             got_last[$];
    bit             stall_prev = 0;
    logic [SDW-1:0] prev_data = '0;

    always @(negedge clk) begin
        chk("sts_state", sts_state, m_state);
        chk("sti_tready", bus.sti_tready, m_state != ST_READ);
        chk("sto_tvalid", bus.sto_tvalid, m_valid);
        if (m_valid && m_rd.size() > 0) begin
            chk("sto_tdata", bus.sto_tdata, m_rd[0]);
            chk("sto_tlast", bus.sto_tlast, m_rd.size() == 1);
        end else begin
            chk("sto_tlast_idle", bus.sto_tlast, 0);
        end
        if (stall_prev && bus.sto_tvalid) chk("stall_hold", bus.sto_tdata, prev_data);
        stall_prev = bus.sto_tvalid && !bus.sto_tready;
        prev_data  = bus.sto_tdata;
        if (bus.sto_tvalid && bus.sto_tready) begin
            got.push_back(bus.sto_tdata);
            got_last.push_back(bus.sto_tlast);
        end
    end

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       bus.sto_tready = 1'b1;
            1:       bus.sto_tready = !bus.sto_tready;
            default: bus.sto_tready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(logic [SDW-1:0] d, logic [SEW-1:0] ev);
        bus.sti_tvalid = 1'b1;
        bus.sti_tdata  = d;
        bus.sti_tevent = ev;
        step();
        bus.sti_tvalid = 1'b0;
        bus.sti_tevent = '0;
    endtask

    task automatic wait_idle(string name);
        int guard = 0;
        while (sts_state != ST_IDLE && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) chk(name, sts_state, ST_IDLE);
    endtask

    task automatic capture(int n, int trig, int dly, logic [SEW-1:0] mask,
                           logic [SEW-1:0] tev, bit rnd, int rm);
        int i = 0;
        int guard = 0;
        bit v;
        rmode = rm;
        got.delete();
        got_last.delete();
        cfg_mask = mask;
        cfg_dly  = AW'(dly);
        cfg_arm  = 1'b1;
        step();
        cfg_arm = 1'b0;
        while (i < n && bus.sti_tready && guard < 500) begin
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.sti_tvalid = v;
            bus.sti_tdata  = rnd ? SDW'($urandom) : SDW'(i);
            if (i == trig)     bus.sti_tevent = tev;
            else if (!rnd)     bus.sti_tevent = '0;
            else if (i < trig) bus.sti_tevent = SEW'($urandom) & ~mask;
            else               bus.sti_tevent = SEW'($urandom);
            step();
            if (v) begin
                if (i == trig) begin
                    cfg_mask = SEW'($urandom);
                    cfg_dly  = AW'($urandom);
                end
                i++;
            end
            guard++;
        end
        bus.sti_tvalid = 1'b0;
        bus.sti_tevent = '0;
        wait_idle("capture_timeout");
    endtask

    initial begin
        bus.sti_tvalid = 1'b0;
        bus.sti_tevent = '0;
        bus.sti_tdata  = '0;
        bus.sto_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", bus.sti_tready, 1);
        chk("rst_state", sts_state, ST_IDLE);
        chk("rst_tvalid", bus.sto_tvalid, 0);
        chk("rst_tdata", bus.sto_tdata, 0);
        rst = 1'b0;
        step();

        capture(5, 4, 0, 8'h01, 8'h01, 0, 0);
        chk("r36_len", got.size(), 5);
        for (int k = 0; k < got.size() && k < 5; k++) chk("r36_data", got[k], k);
        if (got.size() == 5) begin
            chk("r36_last", got_last[4], 1);
            chk("r36_notlast", got_last[3], 0);
        end
        chk("r36_idle", sts_state, ST_IDLE);

        for (int pass = 0; pass < 2; pass++) begin
            capture(40, 30, 3, 8'h10, 8'h30, 0, pass);
            chk("r37_len", got.size(), 16);
            for (int k = 0; k < got.size() && k < 16; k++) chk("r37_data", got[k], 18 + k);
            if (got.size() == 16) chk("r37_last", got_last[15], 1);
        end

        capture(16, 15, 0, 8'h80, 8'h80, 0, 0);
        chk("wrap_len", got.size(), 16);
        for (int k = 0; k < got.size() && k < 16; k++) chk("wrap_data", got[k], k);

        rmode = 0;
        cfg_mask = 8'h01;
        cfg_dly  = 4'd10;
        cfg_arm  = 1'b1;
        step();
        cfg_arm = 1'b0;
        for (int k = 0; k < 5; k++) feed(SDW'(k), (k == 2) ? 8'h01 : 8'h00);
        chk("r39_post", sts_state, ST_POST);
        cfg_abort = 1'b1;
        cfg_arm   = 1'b1;
        feed(32'hAA, 8'h01);
        cfg_abort = 1'b0;
        cfg_arm   = 1'b0;
        chk("r39_idle", sts_state, ST_IDLE);
        repeat (20) step();
        chk("r39_still_idle", sts_state, ST_IDLE);

        for (int k = 0; k < 4; k++) feed(SDW'(k), 8'hFF);
        chk("r40_idle", sts_state, ST_IDLE);
        cfg_mask = 8'h01;
        cfg_dly  = 4'd0;
        cfg_arm  = 1'b1;
        step();
        cfg_arm = 1'b0;
        for (int k = 0; k < 5; k++) feed(SDW'(k), 8'h02);
        chk("r40_armed", sts_state, ST_ARMED);
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        chk("r40_abort", sts_state, ST_IDLE);

        got.delete();
        got_last.delete();
        cfg_arm = 1'b1;
        step();
        cfg_arm = 1'b0;
        for (int k = 0; k < 5; k++) feed(SDW'(k), (k == 4) ? 8'h01 : 8'h00);
        begin
            int guard = 0;
            while (got.size() < 3 && guard < 50) begin
                step();
                guard++;
            end
            chk("r41_three", got.size(), 3);
        end
        rst = 1'b1;
        step();
        chk("r41_tvalid", bus.sto_tvalid, 0);
        chk("r41_state", sts_state, ST_IDLE);
        chk("r41_tready", bus.sti_tready, 1);
        rst = 1'b0;
        step();

        for (int r = 0; r < 10; r++) begin
            int trig;
            int dly;
            int n;
            logic [SEW-1:0] mask;
            trig = $urandom_range(0, 25);
            dly  = $urandom_range(0, 15);
            n    = trig + dly + 1;
            mask = SEW'(1 << $urandom_range(0, SEW - 1));
            capture(n, trig, dly, mask, mask | SEW'($urandom), 1, 2);
            chk("rand_len", got.size(), (n < 16) ? n : 16);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
